pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage pipeline latches (FD, DX, XM, MW) and the PC register. It decodes the FD/DX instruction words and detects load-use hazards, taken control transfers and multicycle mult/div operations. From these it drives per-latch write-enables and NOP-insert (flush) controls. It also owns the start/ready handshake with the multdiv unit, including a timeout.

---
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - Decode inputs, latch controls and multdiv handshake of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      fd_ir;
  logic [31:0]      dx_ir;
  logic             branch_taken;
  logic             md_ready;
  logic             pc_we;
  logic             fd_we;
  logic             dx_we;
  logic             fd_flush;
  logic             dx_flush;
  logic             xm_flush;
  logic             md_start;
  logic             md_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output fd_ir, dx_ir, branch_taken, md_ready,
    input  pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
    input  md_start, md_error, stall_cycles, flush_count
  );

  modport slave (
    input  fd_ir, dx_ir, branch_taken, md_ready,
    output pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
    output md_start, md_error, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - Pipeline stall/flush sequencer with multdiv handshake; HAZARD_STATS_EN enables counters.
module pipeline_hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   bus
);
  localparam int TMR_W = $clog2(MD_MAX_CYCLES + 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MD_WAIT    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_timer;
  logic             r_md_error;

  logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
  logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;
  logic       w_rd_rs, w_rd_rt, w_rd_rd;
  logic       w_load_use, w_dx_md, w_timeout, w_set_err;
  logic       w_pc_we, w_fd_we, w_dx_we, w_fd_flush, w_dx_flush, w_xm_flush, w_md_start;
  logic       w_unused_ir;

  assign w_fd_op  = bus.fd_ir[31:27];
  assign w_fd_rd  = bus.fd_ir[26:22];
  assign w_fd_rs  = bus.fd_ir[21:17];
  assign w_fd_rt  = bus.fd_ir[16:12];
  assign w_dx_op  = bus.dx_ir[31:27];
  assign w_dx_rd  = bus.dx_ir[26:22];
  assign w_dx_alu = bus.dx_ir[6:2];

  assign w_unused_ir = &{1'b0, bus.fd_ir[11:0], bus.dx_ir[21:7], bus.dx_ir[1:0]};

  assign w_rd_rs = (w_fd_op == OP_RTYPE) || (w_fd_op == OP_ADDI) || (w_fd_op == OP_LW) ||
                   (w_fd_op == OP_SW) || (w_fd_op == OP_BNE) || (w_fd_op == OP_BLT);
  assign w_rd_rt = (w_fd_op == OP_RTYPE);
  assign w_rd_rd = (w_fd_op == OP_SW) || (w_fd_op == OP_BNE) || (w_fd_op == OP_BLT) ||
                   (w_fd_op == OP_JR);

  // $0 is hardwired, so a load targeting it never creates a dependency
  assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                      ((w_rd_rs && (w_fd_rs == w_dx_rd)) ||
                       (w_rd_rt && (w_fd_rt == w_dx_rd)) ||
                       (w_rd_rd && (w_fd_rd == w_dx_rd)));

  assign w_dx_md   = (w_dx_op == OP_RTYPE) && ((w_dx_alu == 5'b00110) || (w_dx_alu == 5'b00111));
  assign w_timeout = (r_timer == TMR_W'(MD_MAX_CYCLES - 1));

  // Outputs are held at their reset values while reset is low so a mul in DX cannot pulse md_start
  always_comb begin
    w_next     = r_state;
    w_pc_we    = 1'b1;
    w_fd_we    = 1'b1;
    w_dx_we    = 1'b1;
    w_fd_flush = 1'b0;
    w_dx_flush = 1'b0;
    w_xm_flush = 1'b0;
    w_md_start = 1'b0;
    w_set_err  = 1'b0;
    if (reset) begin
      case (r_state)
        RUN: begin
          if (bus.branch_taken) begin
            w_fd_flush = 1'b1;
            w_dx_flush = 1'b1;
          end else if (w_dx_md) begin
            w_md_start = 1'b1;
            w_pc_we    = 1'b0;
            w_fd_we    = 1'b0;
            w_dx_we    = 1'b0;
            w_xm_flush = 1'b1;
            w_next     = MD_WAIT;
          end else if (w_load_use) begin
            w_pc_we    = 1'b0;
            w_fd_we    = 1'b0;
            w_dx_flush = 1'b1;
            w_next     = LOAD_STALL;
          end
        end
        LOAD_STALL: w_next = RUN;
        MD_WAIT: begin
          if (bus.md_ready || w_timeout) begin
            w_set_err = !bus.md_ready;
            w_next    = RUN;
          end else begin
            w_pc_we    = 1'b0;
            w_fd_we    = 1'b0;
            w_dx_we    = 1'b0;
            w_xm_flush = 1'b1;
          end
        end
        default: w_next = RUN;
      endcase
    end
  end

  // Timer restarts on every MD_WAIT entry because it is held at zero outside that state
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_timer    <= '0;
      r_md_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == MD_WAIT) begin
        r_timer <= r_timer + 1'b1;
      end else begin
        r_timer <= '0;
      end
      if (w_set_err) begin
        r_md_error <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_flush_evt;

  assign w_flush_evt = (r_state == RUN) && bus.branch_taken;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_we && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_cycles = r_stall_cnt;
  assign bus.flush_count  = r_flush_cnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

  assign bus.pc_we    = w_pc_we;
  assign bus.fd_we    = w_fd_we;
  assign bus.dx_we    = w_dx_we;
  assign bus.fd_flush = w_fd_flush;
  assign bus.dx_flush = w_dx_flush;
  assign bus.xm_flush = w_xm_flush;
  assign bus.md_start = w_md_start;
  assign bus.md_error = r_md_error;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - Directed and random checks of pipeline_hazard_ctrl against a cycle model.
module tb_pipeline_hazard_ctrl;
  localparam int MAXC  = 40;
  localparam int CNT_W = 16;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] LW3 = 32'h40C2_0000;
  localparam logic [31:0] ADD = 32'h0106_2000;
  localparam logic [31:0] LW0 = 32'h4002_0000;
  localparam logic [31:0] MUL = 32'h0142_2018;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  int          starts;
  int          m_age;
  bit          m_ls;
  bit          m_err;
  int unsigned m_stall;
  int unsigned m_flush;

  function automatic logic [31:0] enc(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  // Load-use from a table of the registers each FD opcode reads
  function automatic bit m_load_use(input logic [31:0] fd, input logic [31:0] dx);
    int srcs[$];
    int dst;
    dst = int'(dx[26:22]);
    if (dx[31:27] != 5'b01000 || dst == 0) return 1'b0;
    case (fd[31:27])
      5'b00000:                   begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[16:12])); end
      5'b00101, 5'b01000:         srcs.push_back(int'(fd[21:17]));
      5'b00111, 5'b00010, 5'b00110: begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[26:22])); end
      5'b00100:                   srcs.push_back(int'(fd[26:22]));
      default: ;
    endcase
    foreach (srcs[i]) if (srcs[i] == dst) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_age = -1; m_ls = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // Assert reset between edges and check the outputs immediately
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_ctl", {24'd0, bus.pc_we, bus.fd_we, bus.dx_we, bus.fd_flush, bus.dx_flush,
                    bus.xm_flush, bus.md_start, bus.md_error}, 32'h0000_00E0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush", 32'(bus.flush_count), 32'd0);
    @(negedge clock);
    #1;
    bus.fd_ir = NOP; bus.dx_ir = NOP; bus.branch_taken = 0; bus.md_ready = 0;
    reset = 1'b1;
    starts = 0;
  endtask

  // One clock: drive inputs, compare at the non-active edge, advance the model
  task automatic cycle(input logic [31:0] fd, input logic [31:0] dx, input logic bt, input logic rdy);
    logic [7:0] e;
    bit         rel;
    bus.fd_ir = fd; bus.dx_ir = dx; bus.branch_taken = bt; bus.md_ready = rdy;
    @(posedge clock);
    e = {3'b111, 4'b0000, m_err};
    if (m_age >= 0) begin
      rel = rdy || (m_age == MAXC - 1);
      if (!rel) begin e[7:5] = 3'b000; e[2] = 1'b1; end
      if (!rdy && m_age == MAXC - 1) m_err = 1;
      m_age = rel ? -1 : m_age + 1;
    end else if (m_ls) begin
      m_ls = 0;
    end else if (bt) begin
      e[4] = 1; e[3] = 1;
    end else if (is_md(dx)) begin
      e[7:5] = 3'b000; e[2] = 1; e[1] = 1; m_age = 0;
    end else if (m_load_use(fd, dx)) begin
      e[7] = 0; e[6] = 0; e[3] = 1; m_ls = 1;
    end
    if (bus.md_start === 1'b1) starts++;
    chk("ctl", {24'd0, bus.pc_we, bus.fd_we, bus.dx_we, bus.fd_flush, bus.dx_flush,
                bus.xm_flush, bus.md_start, bus.md_error}, {24'd0, e});
    chk("stall", 32'(bus.stall_cycles), STATS ? m_stall : 32'd0);
    chk("flush", 32'(bus.flush_count), STATS ? m_flush : 32'd0);
    if (!e[7] && m_stall < (2**CNT_W - 1)) m_stall++;
    if (e[4] && m_flush < (2**CNT_W - 1)) m_flush++;
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic [4:0] ops [9];
    logic [31:0] fd, dx;
    ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00010, 5'b00110, 5'b00100, 5'b00001, 5'b00011};
    bus.fd_ir = MUL; bus.dx_ir = MUL; bus.branch_taken = 1; bus.md_ready = 1;
    #3;
    do_reset();

    // load-use stall, one free cycle, then normal flow
    cycle(ADD, LW3, 0, 0);
    cycle(ADD, NOP, 0, 0);
    cycle(NOP, NOP, 0, 0);
    chk("lu_stall", 32'(bus.stall_cycles), STATS ? 32'd1 : 32'd0);

    // load to $0 creates no hazard
    do_reset();
    cycle(enc(5'd0, 5'd4, 5'd0, 5'd0, 5'd0), LW0, 0, 0);
    chk("r0_pc_we", 32'(bus.pc_we), 32'd1);

    // branch beats load-use
    do_reset();
    cycle(ADD, LW3, 1, 0);
    cycle(NOP, NOP, 0, 0);
    chk("br_flush", 32'(bus.flush_count), STATS ? 32'd1 : 32'd0);
    chk("br_stall", 32'(bus.stall_cycles), 32'd0);

    // multdiv released by ready 17 cycles after start
    do_reset();
    cycle(NOP, MUL, 0, 0);
    for (int i = 0; i < 16; i++) cycle(NOP, MUL, 1'b0, 1'b0);
    cycle(NOP, MUL, 0, 1);
    cycle(NOP, NOP, 0, 0);
    chk("md_starts", 32'(starts), 32'd1);
    chk("md_stall", 32'(bus.stall_cycles), STATS ? 32'd17 : 32'd0);

    // timeout after 40 wait cycles, error sticks
    do_reset();
    cycle(NOP, MUL, 0, 0);
    for (int i = 0; i < MAXC; i++) cycle(NOP, MUL, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(NOP, NOP, 1'b1, 1'b0);
    chk("to_err", 32'(bus.md_error), 32'd1);
    chk("to_stall", 32'(bus.stall_cycles), STATS ? 32'd40 : 32'd0);

    // reset in the middle of a wait
    do_reset();
    cycle(NOP, MUL, 0, 0);
    for (int i = 0; i < 5; i++) cycle(NOP, MUL, 1'b0, 1'b0);
    do_reset();
    cycle(NOP, NOP, 0, 0);
    chk("rst_md_starts", 32'(starts), 32'd0);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: dx = enc(5'b01000, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, 5'd0);
        4:          dx = enc(5'd0, 5'd5, 5'd1, 5'd2, 5'($urandom_range(6, 7)));
        default:    dx = enc(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
      endcase
      fd = enc(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
      cycle(fd, dx, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
